// File: rtl/st_channel_adapter_pipe_pkg.sv
// Shared definitions for the channel adapter pipeline.
//   pkt_state_t : packet FSM state (idle / forwarding a packet / dropping a packet)
//   SKID_DEPTH  : number of entries in the output skid buffer
package st_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } pkt_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry skid buffer with registered output and registered ready.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data (caller guarantees push_ready was high)
//   push_data   : payload to store
//   push_ready  : registered; high when occupancy after this cycle is < SKID_DEPTH
//   pop_valid   : head entry is valid
//   pop_ready   : consumer takes the head entry this cycle
//   pop_data    : head entry (held stable while pop_valid & !pop_ready)
module st_skid_buffer
  import st_adapter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             pop;

  assign pop_valid = (occ != 2'd0);
  assign pop_data  = head;
  assign pop       = pop_valid & pop_ready;

  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      push_ready <= 1'b0;
    end else begin
      occ        <= occ_next;
      push_ready <= (occ_next < 2'(SKID_DEPTH));
      // Head always holds the oldest beat; a push lands in head only when
      // head is empty or being consumed with nothing queued behind it.
      if (pop) begin
        if (occ == 2'd2) begin
          head <= tail;
        end else if (push) begin
          head <= push_data;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          head <= push_data;
        end else begin
          tail <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/st_channel_adapter_pipe.sv
// Streaming channel adapter: latches the channel of each packet on its SOP
// beat, forwards beats with that channel widened to OUT_CH_W, and discards
// packets with an out-of-range channel as well as orphan (non-SOP) beats.
//   clk, reset                          : clock, synchronous active-high reset
//   in_valid/in_ready/in_data           : sink handshake and data
//   in_channel                          : sink channel, used on SOP beats only
//   in_startofpacket/in_endofpacket     : sink packet delimiters
//   out_valid/out_ready/out_data        : source handshake and data
//   out_channel                         : latched channel, zero-extended
//   out_startofpacket/out_endofpacket   : source packet delimiters
//   drop_count                          : saturating count of dropped packets / orphan beats
//   proto_err                           : one-cycle pulse on protocol violation
module st_channel_adapter_pipe
  import st_adapter_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IN_CH_W     = 1,
  parameter int unsigned OUT_CH_W    = 8,
  parameter int unsigned MAX_CHANNEL = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                in_ready,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [IN_CH_W-1:0]  in_channel,
  input  logic                in_startofpacket,
  input  logic                in_endofpacket,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                out_startofpacket,
  output logic                out_endofpacket,
  output logic [DATA_W-1:0]   out_data,
  output logic [OUT_CH_W-1:0] out_channel,
  output logic [CNT_W-1:0]    drop_count,
  output logic                proto_err
);

  localparam int unsigned PAY_W = DATA_W + OUT_CH_W + 2;

  pkt_state_t          state;
  pkt_state_t          state_next;
  logic [OUT_CH_W-1:0] chan_q;
  logic [OUT_CH_W-1:0] chan_next;
  logic [OUT_CH_W-1:0] fwd_chan;
  logic [OUT_CH_W-1:0] in_chan_ext;
  logic                accept;
  logic                ch_ok;
  logic                fwd;
  logic                count_drop;
  logic                err;
  logic [PAY_W-1:0]    pay_in;
  logic [PAY_W-1:0]    pay_out;

  assign accept      = in_valid & in_ready;
  assign in_chan_ext = OUT_CH_W'(in_channel);
  assign ch_ok       = (32'(in_channel) <= MAX_CHANNEL);

  // A SOP beat restarts packet handling from any state; it is only an error
  // when it interrupts an open packet (forwarded or being dropped).
  always_comb begin
    state_next = state;
    chan_next  = chan_q;
    fwd_chan   = chan_q;
    fwd        = 1'b0;
    count_drop = 1'b0;
    err        = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        err = (state != ST_IDLE);
        if (ch_ok) begin
          fwd        = 1'b1;
          fwd_chan   = in_chan_ext;
          chan_next  = in_chan_ext;
          state_next = in_endofpacket ? ST_IDLE : ST_PKT;
        end else begin
          count_drop = 1'b1;
          state_next = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            count_drop = 1'b1;
            err        = 1'b1;
          end
          ST_PKT: begin
            fwd = 1'b1;
            if (in_endofpacket) state_next = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      chan_q     <= '0;
      drop_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state     <= state_next;
      chan_q    <= chan_next;
      proto_err <= err;
      if (count_drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  assign pay_in = {in_startofpacket, in_endofpacket, fwd_chan, in_data};

  st_skid_buffer #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fwd),
    .push_data (pay_in),
    .push_ready(in_ready),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (pay_out)
  );

  assign {out_startofpacket, out_endofpacket, out_channel, out_data} = pay_out;

endmodule

// File: tb/tb_st_channel_adapter_pipe.sv
// Self-checking bench for st_channel_adapter_pipe: a directed vector table for
// single-beat behaviour plus hand-written backpressure, reset and drop/saturation
// sequences. A second instance with MAX_CHANNEL=0 and a 2-bit drop counter
// covers whole-packet drops and counter saturation.
module tb_st_channel_adapter_pipe;

  logic       clk;
  logic       reset;
  logic       in_ready, in_valid, sop, eop, out_ready;
  logic [7:0] in_data;
  logic [1:0] in_channel;
  logic       out_valid, out_sop, out_eop, proto_err;
  logic [7:0] out_data, out_channel;
  logic [15:0] drop_count;

  logic       z_in_ready, z_in_valid, z_sop, z_eop, z_out_ready;
  logic [7:0] z_in_data;
  logic [0:0] z_in_channel;
  logic       z_out_valid, z_out_sop, z_out_eop, z_proto_err;
  logic [7:0] z_out_data, z_out_channel;
  logic [1:0] z_drop_count;

  int checks = 0;
  int errors = 0;

  st_channel_adapter_pipe #(
    .DATA_W(8), .IN_CH_W(2), .OUT_CH_W(8), .MAX_CHANNEL(1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_startofpacket(sop), .in_endofpacket(eop),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop),
    .out_data(out_data), .out_channel(out_channel),
    .drop_count(drop_count), .proto_err(proto_err)
  );

  st_channel_adapter_pipe #(
    .DATA_W(8), .IN_CH_W(1), .OUT_CH_W(8), .MAX_CHANNEL(0), .CNT_W(2)
  ) dut0 (
    .clk(clk), .reset(reset),
    .in_ready(z_in_ready), .in_valid(z_in_valid), .in_data(z_in_data),
    .in_channel(z_in_channel), .in_startofpacket(z_sop), .in_endofpacket(z_eop),
    .out_ready(z_out_ready), .out_valid(z_out_valid),
    .out_startofpacket(z_out_sop), .out_endofpacket(z_out_eop),
    .out_data(z_out_data), .out_channel(z_out_channel),
    .drop_count(z_drop_count), .proto_err(z_proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v, s, e;
    logic [1:0] ch;
    logic [7:0] d;
    logic       ov, os, oe;
    logic [7:0] oc, od;
    logic       perr;
    logic [15:0] drop;
  } vec_t;

  function automatic vec_t mk(input logic v, s, e, input logic [1:0] ch, input logic [7:0] d,
                              input logic ov, os, oe, input logic [7:0] oc, od,
                              input logic perr, input logic [15:0] drop);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.ch = ch; r.d = d;
    r.ov = ov; r.os = os; r.oe = oe; r.oc = oc; r.od = od;
    r.perr = perr; r.drop = drop;
    return r;
  endfunction

  vec_t vecs[18];

  initial begin
    int acc;
    int k;
    int ir_low;
    logic [7:0] rx[$];
    string tag;

    //        v  s  e  ch  data    ov os oe och  odata   perr drop
    vecs[0]  = mk(1, 1, 0, 1, 8'h11, 1, 1, 0, 1, 8'h11, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 8'h22, 1, 0, 0, 1, 8'h22, 0, 0);
    vecs[2]  = mk(1, 0, 1, 1, 8'h33, 1, 0, 1, 1, 8'h33, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 8'h44, 0, 0, 0, 0, 8'h00, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1);
    vecs[6]  = mk(1, 1, 0, 2, 8'h55, 0, 0, 0, 0, 8'h00, 0, 2);
    vecs[7]  = mk(1, 0, 0, 0, 8'h66, 0, 0, 0, 0, 8'h00, 0, 2);
    vecs[8]  = mk(1, 0, 1, 0, 8'h77, 0, 0, 0, 0, 8'h00, 0, 2);
    vecs[9]  = mk(1, 1, 1, 0, 8'h88, 1, 1, 1, 0, 8'h88, 0, 2);
    vecs[10] = mk(1, 1, 1, 3, 8'h99, 0, 0, 0, 0, 8'h00, 0, 3);
    vecs[11] = mk(1, 1, 0, 1, 8'hA1, 1, 1, 0, 1, 8'hA1, 0, 3);
    vecs[12] = mk(1, 1, 0, 0, 8'hA2, 1, 1, 0, 0, 8'hA2, 1, 3);
    vecs[13] = mk(1, 0, 1, 3, 8'hA3, 1, 0, 1, 0, 8'hA3, 0, 3);
    vecs[14] = mk(1, 1, 0, 2, 8'hB1, 0, 0, 0, 0, 8'h00, 0, 4);
    vecs[15] = mk(1, 1, 0, 1, 8'hB2, 1, 1, 0, 1, 8'hB2, 1, 4);
    vecs[16] = mk(1, 0, 1, 0, 8'hB3, 1, 0, 1, 1, 8'hB3, 0, 4);
    vecs[17] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 4);

    reset = 1'b1;
    in_valid = 0; sop = 0; eop = 0; in_data = '0; in_channel = '0; out_ready = 1;
    z_in_valid = 0; z_sop = 0; z_eop = 0; z_in_data = '0; z_in_channel = '0; z_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_channel", 32'(out_channel), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Single-beat vector table, sink always ready to drain
    for (int i = 0; i < 18; i++) begin
      in_valid = vecs[i].v; sop = vecs[i].s; eop = vecs[i].e;
      in_channel = vecs[i].ch; in_data = vecs[i].d;
      step();
      tag = $sformatf("v%0d", i);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk({tag, "_sop"}, 32'(out_sop), 32'(vecs[i].os));
        chk({tag, "_eop"}, 32'(out_eop), 32'(vecs[i].oe));
        chk({tag, "_chan"}, 32'(out_channel), 32'(vecs[i].oc));
        chk({tag, "_data"}, 32'(out_data), 32'(vecs[i].od));
      end
      chk({tag, "_proto_err"}, 32'(proto_err), 32'(vecs[i].perr));
      chk({tag, "_drop"}, 32'(drop_count), 32'(vecs[i].drop));
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
    end

    // 10-beat stream with out_ready low for cycles 3..5
    acc = 0; k = 0; ir_low = 0;
    while (rx.size() < 10 && k < 40) begin
      out_ready = !(k inside {3, 4, 5});
      if (acc < 10) begin
        in_valid = 1; in_data = 8'(acc + 1); sop = (acc == 0); eop = (acc == 9); in_channel = 1;
      end else begin
        in_valid = 0; sop = 0; eop = 0;
      end
      if (k inside {3, 4, 5}) begin
        chk($sformatf("stall%0d_valid", k), 32'(out_valid), 1);
        chk($sformatf("stall%0d_hold", k), 32'(out_data), 3);
      end
      if (acc < 10 && !in_ready) ir_low++;
      if (out_valid && out_ready) rx.push_back(out_data);
      if (in_valid && in_ready) acc++;
      step();
      k++;
    end
    in_valid = 0; sop = 0; eop = 0; out_ready = 1;
    chk("stream_accepted", 32'(acc), 10);
    chk("stream_received", 32'(rx.size()), 10);
    for (int i = 0; i < rx.size(); i++)
      chk($sformatf("stream_beat%0d", i), 32'(rx[i]), 32'(i + 1));
    chk("stream_ready_low_cycles", 32'(ir_low), 3);
    chk("stream_total_cycles", 32'(k), 14);

    // Reset with two beats buffered
    out_ready = 0;
    in_valid = 1; sop = 1; eop = 0; in_channel = 1; in_data = 8'hC1;
    step();
    sop = 0; in_data = 8'hC2;
    step();
    in_valid = 0;
    chk("prerst_out_valid", 32'(out_valid), 1);
    chk("prerst_in_ready", 32'(in_ready), 0);
    chk("prerst_drop", 32'(drop_count), 4);
    reset = 1;
    step();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_drop", 32'(drop_count), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    reset = 0; out_ready = 1;
    step();
    chk("afterrst_in_ready", 32'(in_ready), 1);
    chk("afterrst_out_valid", 32'(out_valid), 0);
    in_valid = 1; sop = 1; eop = 1; in_channel = 1; in_data = 8'hD1;
    step();
    in_valid = 0; sop = 0; eop = 0;
    chk("afterrst_pkt_valid", 32'(out_valid), 1);
    chk("afterrst_pkt_sop_eop", 32'({out_sop, out_eop}), 3);
    chk("afterrst_pkt_chan", 32'(out_channel), 1);
    chk("afterrst_pkt_data", 32'(out_data), 32'h D1);

    // MAX_CHANNEL=0 instance: 4-beat packet on channel 1 is dropped whole
    for (int i = 0; i < 4; i++) begin
      z_in_valid = 1; z_sop = (i == 0); z_eop = (i == 3); z_in_channel = 1; z_in_data = 8'(8'hE0 + i);
      step();
      chk($sformatf("z_beat%0d_out_valid", i), 32'(z_out_valid), 0);
      chk($sformatf("z_beat%0d_in_ready", i), 32'(z_in_ready), 1);
    end
    chk("z_pkt_drop", 32'(z_drop_count), 1);
    // Orphan beats push the 2-bit counter into saturation
    for (int i = 0; i < 3; i++) begin
      z_in_valid = 1; z_sop = 0; z_eop = 0; z_in_data = 8'(8'hF0 + i);
      step();
      chk($sformatf("z_orphan%0d_perr", i), 32'(z_proto_err), 1);
      chk($sformatf("z_orphan%0d_drop", i), 32'(z_drop_count), (i == 0) ? 2 : 3);
      chk($sformatf("z_orphan%0d_valid", i), 32'(z_out_valid), 0);
    end
    z_in_valid = 0;
    step();
    chk("z_perr_clear", 32'(z_proto_err), 0);
    chk("z_drop_saturated", 32'(z_drop_count), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
